// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pattern controls in, sync/colour/coordinate stream out.
interface vga_timing_gen_if #(
    parameter int COLOR_BITS = 3,
    parameter int XW         = 10,
    parameter int YW         = 9
);
    logic [1:0]              mode;
    logic [3*COLOR_BITS-1:0] solid_rgb;
    logic                    hsync;
    logic                    vsync;
    logic [COLOR_BITS-1:0]   red;
    logic [COLOR_BITS-1:0]   green;
    logic [COLOR_BITS-1:0]   blue;
    logic                    de;
    logic [XW-1:0]           x;
    logic [YW-1:0]           y;
    logic                    frame_start;

    modport master (
        input  mode, solid_rgb,
        output hsync, vsync, red, green, blue, de, x, y, frame_start
    );

    modport slave (
        output mode, solid_rgb,
        input  hsync, vsync, red, green, blue, de, x, y, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, sync pulses and test-pattern colour generator.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int COLOR_BITS = 3,
    parameter int CHECK_LOG2 = 3
) (
    input logic clk,
    input logic rst_n,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam int CW = 3 * COLOR_BITS;

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [1:0]    mode_q, mode_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, fs_q, fs_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CW-1:0] rgb_q, rgb_d;
    logic          h_wrap, origin, h_act, v_act, chk;
    logic [2:0]    bar;

    // Next counter state plus the registered-output image of the current counter state.
    always_comb begin
        h_wrap  = h_cnt_q == HW'(H_TOTAL - 1);
        h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = !h_wrap ? v_cnt_q : (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
        origin  = h_cnt_q == '0 && v_cnt_q == '0;
        mode_d  = origin ? vga.mode : mode_q;
        de_d    = h_cnt_q < HW'(H_ACTIVE) && v_cnt_q < VW'(V_ACTIVE);
        h_act   = h_cnt_q >= HW'(H_ACTIVE + H_FP) && h_cnt_q < HW'(H_ACTIVE + H_FP + H_SYNC);
        v_act   = v_cnt_q >= VW'(V_ACTIVE + V_FP) && v_cnt_q < VW'(V_ACTIVE + V_FP + V_SYNC);
        hsync_d = SYNC_POL ? h_act : ~h_act;
        vsync_d = SYNC_POL ? v_act : ~v_act;
        fs_d    = origin && de_d;
        x_d     = de_d ? h_cnt_q[XW-1:0] : '0;
        y_d     = de_d ? v_cnt_q[YW-1:0] : '0;
        bar     = 3'((32'(h_cnt_q) << 3) / H_ACTIVE);
        chk     = h_cnt_q[CHECK_LOG2] ^ v_cnt_q[CHECK_LOG2];
        rgb_d   = !de_d            ? '0 :
                  mode_d == 2'd0   ? {{COLOR_BITS{bar[2]}}, {COLOR_BITS{bar[1]}}, {COLOR_BITS{bar[0]}}} :
                  mode_d == 2'd1   ? {CW{chk}} :
                  mode_d == 2'd2   ? {3{h_cnt_q[COLOR_BITS-1:0]}} :
                                     vga.solid_rgb;
    end

    // Counter, latched mode and output registers; reset forces idle sync levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            mode_q  <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            rgb_q   <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            mode_q  <= mode_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            fs_q    <= fs_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rgb_q   <= rgb_d;
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.de          = de_q;
    assign vga.frame_start = fs_q;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign {vga.red, vga.green, vga.blue} = rgb_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed vector table plus multi-cycle sequences for vga_timing_gen.
module tb_vga_timing_gen;
    localparam int HT = 15;
    localparam int VT = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.COLOR_BITS(3), .XW(3), .YW(2)) vif ();

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .COLOR_BITS(3), .CHECK_LOG2(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .vga(vif)
    );

    typedef struct {
        logic [1:0] mode;
        logic [8:0] solid;
        int h, v, r, g, b, de, x, y, hs, vs, fs;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string n, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", n, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_rgb(input string n, input int r, input int g, input int b);
        chk({n, "_r"}, int'(vif.red), r);
        chk({n, "_g"}, int'(vif.green), g);
        chk({n, "_b"}, int'(vif.blue), b);
    endtask

    task automatic chk_idle(input string n);
        chk({n, "_hs"}, int'(vif.hsync), 1);
        chk({n, "_vs"}, int'(vif.vsync), 1);
        chk({n, "_de"}, int'(vif.de), 0);
        chk({n, "_fs"}, int'(vif.frame_start), 0);
        chk({n, "_x"}, int'(vif.x), 0);
        chk({n, "_y"}, int'(vif.y), 0);
        chk_rgb(n, 0, 0, 0);
    endtask

    initial begin
        int hs_low, vs_low, de_hi, fs_hi, hs_bad, vs_bad, de_bad, fs_bad;
        // mode solid h v  r g b de x y hs vs fs
        tbl[0]  = '{2'd0, 9'o000,  5, 0, 7, 0, 7, 1, 5, 0, 1, 1, 0};
        tbl[1]  = '{2'd0, 9'o000,  2, 1, 0, 7, 0, 1, 2, 1, 1, 1, 0};
        tbl[2]  = '{2'd1, 9'o000,  2, 0, 7, 7, 7, 1, 2, 0, 1, 1, 0};
        tbl[3]  = '{2'd1, 9'o000,  2, 2, 0, 0, 0, 1, 2, 2, 1, 1, 0};
        tbl[4]  = '{2'd1, 9'o000,  0, 2, 7, 7, 7, 1, 0, 2, 1, 1, 0};
        tbl[5]  = '{2'd3, 9'o524,  3, 1, 5, 2, 4, 1, 3, 1, 1, 1, 0};
        tbl[6]  = '{2'd3, 9'o524,  9, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        tbl[7]  = '{2'd3, 9'o524, 11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[8]  = '{2'd2, 9'o000,  6, 3, 6, 6, 6, 1, 6, 3, 1, 1, 0};
        tbl[9]  = '{2'd2, 9'o000,  0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1};
        tbl[10] = '{2'd0, 9'o000,  0, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[11] = '{2'd0, 9'o000, 12, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{2'd2, 9'o000,  3, 4, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        tbl[13] = '{2'd0, 9'o000,  7, 3, 7, 7, 7, 1, 7, 3, 1, 1, 0};
        vif.mode = 2'd0;
        vif.solid_rgb = 9'o000;

        step(2);
        chk_idle("reset");

        for (int i = 0; i < 14; i++) begin
            vif.mode = tbl[i].mode;
            vif.solid_rgb = tbl[i].solid;
            do_reset();
            step(tbl[i].v * HT + tbl[i].h + 1);
            chk_rgb($sformatf("v%0d", i), tbl[i].r, tbl[i].g, tbl[i].b);
            chk($sformatf("v%0d_de", i), int'(vif.de), tbl[i].de);
            chk($sformatf("v%0d_x", i), int'(vif.x), tbl[i].x);
            chk($sformatf("v%0d_y", i), int'(vif.y), tbl[i].y);
            chk($sformatf("v%0d_hs", i), int'(vif.hsync), tbl[i].hs);
            chk($sformatf("v%0d_vs", i), int'(vif.vsync), tbl[i].vs);
            chk($sformatf("v%0d_fs", i), int'(vif.frame_start), tbl[i].fs);
        end

        vif.mode = 2'd3;
        vif.solid_rgb = 9'o777;
        do_reset();
        {hs_low, vs_low, de_hi, fs_hi, hs_bad, vs_bad, de_bad, fs_bad} = '0;
        for (int k = 0; k < 3 * HT * VT; k++) begin
            step(1);
            hs_low += int'(!vif.hsync);
            vs_low += int'(!vif.vsync);
            de_hi  += int'(vif.de);
            fs_hi  += int'(vif.frame_start);
            hs_bad += int'(vif.hsync != !((k % HT) >= 10 && (k % HT) <= 12));
            vs_bad += int'(vif.vsync != !(((k / HT) % VT) >= 5 && ((k / HT) % VT) <= 6));
            de_bad += int'(vif.de != ((k % HT) < 8 && ((k / HT) % VT) < 4));
            fs_bad += int'(vif.frame_start != (k % (HT * VT) == 0));
        end
        chk("run_hs_low", hs_low, 72);
        chk("run_vs_low", vs_low, 90);
        chk("run_de_hi", de_hi, 96);
        chk("run_fs_hi", fs_hi, 3);
        chk("run_hs_pos", hs_bad, 0);
        chk("run_vs_pos", vs_bad, 0);
        chk("run_de_pos", de_bad, 0);
        chk("run_fs_pos", fs_bad, 0);

        vif.mode = 2'd0;
        do_reset();
        step(18);
        vif.mode = 2'd1;
        step(18);
        chk_rgb("mchg_same", 7, 0, 7);
        step(87);
        chk_rgb("mchg_next0", 7, 7, 7);
        step(33);
        chk_rgb("mchg_next1", 7, 7, 7);

        vif.mode = 2'd1;
        do_reset();
        step(36);
        chk("arst_pre_de", int'(vif.de), 1);
        chk("arst_pre_x", int'(vif.x), 5);
        #2;
        rst_n = 1'b0;
        vif.mode = 2'd3;
        vif.solid_rgb = 9'o524;
        #1;
        chk_idle("arst");
        #1;
        rst_n = 1'b1;
        step(1);
        chk("arst_post_fs", int'(vif.frame_start), 1);
        chk("arst_post_x", int'(vif.x), 0);
        chk("arst_post_y", int'(vif.y), 0);
        chk("arst_post_de", int'(vif.de), 1);
        chk_rgb("arst_post", 5, 2, 4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in clocks.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in clocks.
REQ-005 SHALL have parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33, vertical equivalents in lines.
REQ-006 SHALL have parameter SYNC_POL, default 0, active sync level (0 = active-low).
REQ-007 SHALL have parameter COLOR_BITS, default 3, bits per colour channel.
REQ-008 SHALL have parameter CHECK_LOG2, default 3, log2 of checkerboard square size.
REQ-009 clk  input  1  pixel clock; all logic rising-edge.
REQ-010 rst_n  input  1  asynchronous active-low reset.
REQ-011 mode  input  2  pattern select: 0 colour bars, 1 checkerboard, 2 gradient, 3 solid.
REQ-012 solid_rgb  input  3*COLOR_BITS  solid colour {r,g,b} for mode 3.
REQ-013 hsync, vsync  output  1 each  sync pulses at SYNC_POL level.
REQ-014 red, green, blue  output  COLOR_BITS each  pixel colour.
REQ-015 de  output  1  high during visible pixels.
REQ-016 x, y  output  clog2(H_ACTIVE), clog2(V_ACTIVE)  coordinates of current visible pixel.
REQ-017 frame_start  output  1  one-cycle pulse on pixel (0,0).

Function
REQ-018 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP), wrapping to 0.
REQ-019 v_cnt SHALL increment when h_cnt wraps, counting 0..V_TOTAL-1 and wrapping to 0 when both wrap together.
REQ-020 Horizontal visible SHALL be h_cnt < H_ACTIVE; vertical visible v_cnt < V_ACTIVE; de = both.
REQ-021 hsync SHALL be active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync likewise on v_cnt, whole lines.
REQ-022 All outputs SHALL be registered, one clock latency from counter state to output.
REQ-023 x, y SHALL equal h_cnt, v_cnt when de; hold 0 when de low.
REQ-024 Colour outputs SHALL be 0 whenever de is low, regardless of mode.
REQ-025 Mode 0: bar = (h_cnt*8)/H_ACTIVE (3 bits); red all-ones if bar[2], green if bar[1], blue if bar[0], else 0.
REQ-026 Mode 1: all channels all-ones if h_cnt[CHECK_LOG2]^v_cnt[CHECK_LOG2], else 0.
REQ-027 Mode 2: all channels = h_cnt[COLOR_BITS-1:0].
REQ-028 Mode 3: {red,green,blue} = solid_rgb, solid_rgb sampled every pixel.
REQ-029 mode SHALL be latched into an internal register only when h_cnt=0 and v_cnt=0; changes mid-frame take effect next frame.
REQ-030 frame_start SHALL be high exactly in the output cycle for h_cnt=0, v_cnt=0, coincident with de.
REQ-031 Multiplication in REQ-025 SHALL be wide enough to avoid overflow for H_ACTIVE up to 4095.

Reset
REQ-032 On rst_n low, counters and latched mode SHALL clear to 0 immediately, asynchronously.
REQ-033 During reset: hsync, vsync = ~SYNC_POL; de, frame_start, x, y, colours = 0.
REQ-034 Reset asserted mid-line SHALL abort the frame; after release the first output cycle reflects h_cnt=0, v_cnt=0 with frame_start=1, the latched mode updated from mode.

Verification (params H 8/2/3/2, V 4/1/2/1, COLOR_BITS=3, CHECK_LOG2=1, SYNC_POL=0)
REQ-035 Free-run 3 frames -> hsync low 3 clocks every 15, vsync low 30 clocks every 120, de high 32 clocks per frame, frame_start every 120 clocks.
REQ-036 mode=0, pixel (5,0) -> red=7, green=0, blue=7; pixel (2,1) -> red=0, green=7, blue=0.
REQ-037 mode=1 -> pixel (2,0) white (7,7,7), pixel (2,2) black, pixel (0,2) white.
REQ-038 mode=3, solid_rgb=9'o524 -> visible pixels red=5, green=2, blue=4; blanking pixels all 0.
REQ-039 mode changed 0->1 at pixel (3,1) -> rest of frame stays bars; next frame checkerboard.
REQ-040 rst_n pulsed low at h_cnt=6, v_cnt=2 -> outputs go to reset values asynchronously; first cycle after release frame_start=1, x=0, y=0, de=1.
